// File: rtl/demux_write_bank_n.sv
// demux_write_bank_n: two-stage one-hot demux into a bank of m registered n-bit entries.
// Define DEMUX_BULK_CLEAR_EN to add clr_i and the DRAIN/CLEAR sweep FSM.
module demux_write_bank_n #(
    parameter int n       = 4,
    parameter int address = 11,
    parameter int m       = 2048
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [address-1:0] sel_i,
    input  logic [n-1:0]       data_i,
    output logic [n-1:0]       data_o [0:m-1],
    output logic               wr_done_o
`ifdef DEMUX_BULK_CLEAR_EN
    ,
    input  logic               clr_i
`endif
);
    localparam int G  = m / 4;
    localparam int KW = address - 2;

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t          state_q;
    logic [KW-1:0]   k_q;
    logic [G-1:0]    grp_q, grp_d;
    logic [1:0]      lo_q;
    logic [n-1:0]    dat_q;
    logic            vld_q, wr_done_q, clr, accept;
    logic [n-1:0]    data_q [0:m-1];

`ifdef DEMUX_BULK_CLEAR_EN
    assign clr = clr_i;
`else
    assign clr = 1'b0;
`endif

    // Clear beats a simultaneous request, so ready drops whenever clr is raised.
    assign ready_o   = rst_ni && state_q == IDLE && !clr;
    assign accept    = valid_i && ready_o;
    assign grp_d     = G'(1) << sel_i[address-1:2];
    assign data_o    = data_q;
    assign wr_done_o = wr_done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            k_q       <= '0;
            grp_q     <= '0;
            lo_q      <= '0;
            dat_q     <= '0;
            vld_q     <= 1'b0;
            wr_done_q <= 1'b0;
            for (int i = 0; i < m; i++) data_q[i] <= '0;
        end else begin
            vld_q     <= accept;
            wr_done_q <= vld_q;
            if (accept) begin
                grp_q <= grp_d;
                lo_q  <= sel_i[1:0];
                dat_q <= data_i;
            end
            for (int g = 0; g < G; g++)
                for (int j = 0; j < 4; j++)
                    if (vld_q && grp_q[g] && lo_q == 2'(j)) data_q[4*g+j] <= dat_q;
            case (state_q)
                IDLE:  if (clr) state_q <= vld_q ? DRAIN : CLEAR;
                DRAIN: state_q <= CLEAR;
                CLEAR: begin
                    for (int j = 0; j < 4; j++) data_q[{k_q, 2'(j)}] <= '0;
                    k_q <= k_q + 1'b1;
                    if (k_q == KW'(G - 1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_demux_write_bank_n.sv
// tb_demux_write_bank_n: scoreboard bench for a small (m=16) and a default (m=2048) bank.
module tb_demux_write_bank_n;
    typedef struct packed {logic [10:0] idx; logic [3:0] dat;} ev_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       s_valid = 1'b0, s_ready, s_done;
    logic [3:0] s_sel = '0, s_data = '0;
    logic [3:0] s_out [0:15];
    logic [3:0] s_mdl [0:15];
    logic       b_valid = 1'b0, b_ready, b_done;
    logic [10:0] b_sel = '0;
    logic [3:0] b_data = '0;
    logic [3:0] b_out [0:2047];
    logic [3:0] b_mdl [0:2047];
`ifdef DEMUX_BULK_CLEAR_EN
    logic       clr = 1'b0;
`endif
    ev_t        s_q[$], b_q[$];
    ev_t        e_s, e_b;
    int         n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    demux_write_bank_n #(.n(4), .address(4), .m(16)) u_small (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(s_valid), .ready_o(s_ready),
        .sel_i(s_sel), .data_i(s_data), .data_o(s_out), .wr_done_o(s_done)
`ifdef DEMUX_BULK_CLEAR_EN
        , .clr_i(clr)
`endif
    );

    demux_write_bank_n u_big (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(b_valid), .ready_o(b_ready),
        .sel_i(b_sel), .data_i(b_data), .data_o(b_out), .wr_done_o(b_done)
`ifdef DEMUX_BULK_CLEAR_EN
        , .clr_i(1'b0)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Each wr_done pulse must match the oldest outstanding write.
    always @(negedge clk) begin
        if (s_done) begin
            if (s_q.size() == 0) chk("small_unexpected_done", 32'(1), 32'(0));
            else begin
                e_s = s_q.pop_front();
                chk("small_wr_landed", 32'(s_out[e_s.idx[3:0]]), 32'(e_s.dat));
            end
        end
        if (b_done) begin
            if (b_q.size() == 0) chk("big_unexpected_done", 32'(1), 32'(0));
            else begin
                e_b = b_q.pop_front();
                chk("big_wr_landed", 32'(b_out[e_b.idx]), 32'(e_b.dat));
            end
        end
    end

    task automatic idle(input int c);
        repeat (c) @(negedge clk);
    endtask

    task automatic s_wr(input logic [3:0] s, input logic [3:0] d);
        s_valid = 1'b1; s_sel = s; s_data = d;
        s_q.push_back({7'd0, s, d});
        s_mdl[s] = d;
        @(negedge clk);
    endtask

    task automatic b_wr(input logic [10:0] s, input logic [3:0] d);
        b_valid = 1'b1; b_sel = s; b_data = d;
        b_q.push_back({s, d});
        b_mdl[s] = d;
        @(negedge clk);
    endtask

    task automatic s_cmp_all(input string nm);
        int bad = 0;
        for (int i = 0; i < 16; i++) if (s_out[i] !== s_mdl[i]) bad++;
        chk(nm, 32'(bad), 32'(0));
    endtask

    task automatic b_cmp_all(input string nm);
        int bad = 0;
        for (int i = 0; i < 2048; i++) if (b_out[i] !== b_mdl[i]) bad++;
        chk(nm, 32'(bad), 32'(0));
    endtask

    task automatic s_zero_model();
        for (int i = 0; i < 16; i++) s_mdl[i] = '0;
    endtask

    initial begin
        s_zero_model();
        for (int i = 0; i < 2048; i++) b_mdl[i] = '0;
        idle(2);
        chk("rst_ready", 32'(s_ready), 32'(0));
        chk("rst_done", 32'(s_done), 32'(0));
        chk("rst_big_ready", 32'(b_ready), 32'(0));
        s_cmp_all("rst_entries");
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", 32'(s_ready), 32'(1));
        chk("big_ready_after_release", 32'(b_ready), 32'(1));
        @(negedge clk);

        s_wr(4'd5, 4'hA); s_valid = 1'b0;
        chk("single_not_yet_written", 32'(s_out[5]), 32'(0));
        @(negedge clk);
        chk("single_written", 32'(s_out[5]), 32'hA);
        idle(2);
        s_cmp_all("single_others_zero");

        s_wr(4'd3, 4'h1); s_wr(4'd3, 4'h7); s_wr(4'd12, 4'hF); s_valid = 1'b0;
        idle(4);
        chk("b2b_later_wins", 32'(s_out[3]), 32'h7);
        chk("b2b_entry12", 32'(s_out[12]), 32'hF);
        s_cmp_all("b2b_all");

`ifdef DEMUX_BULK_CLEAR_EN
        s_wr(4'd9, 4'h6); s_valid = 1'b0; clr = 1'b1;
        chk("clr_req_ready", 32'(s_ready), 32'(0));
        @(negedge clk); clr = 1'b0;
        chk("drain_write_landed", 32'(s_out[9]), 32'h6);
        for (int c = 0; c < 5; c++) begin
            chk("clear_ready_low", 32'(s_ready), 32'(0));
            clr = (c == 2);
            @(negedge clk);
        end
        clr = 1'b0;
        chk("clear_ready_back", 32'(s_ready), 32'(1));
        s_zero_model();
        s_cmp_all("clear_all_zero");

        s_wr(4'd2, 4'h3); s_valid = 1'b0;
        idle(3);
        s_valid = 1'b1; s_sel = 4'd7; s_data = 4'h5; clr = 1'b1;
        chk("simul_ready", 32'(s_ready), 32'(0));
        @(negedge clk); s_valid = 1'b0; clr = 1'b0;
        idle(6);
        s_zero_model();
        s_cmp_all("simul_cleared");
        chk("simul_ready_back", 32'(s_ready), 32'(1));

        s_wr(4'd14, 4'hB); s_valid = 1'b0;
        idle(3);
        chk("pre_rst_entry14", 32'(s_out[14]), 32'hB);
        clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        chk("midclr_rst_ready", 32'(s_ready), 32'(0));
        chk("midclr_rst_done", 32'(s_done), 32'(0));
        chk("midclr_rst_entry14", 32'(s_out[14]), 32'(0));
        s_zero_model();
        s_cmp_all("midclr_rst_entries");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midclr_release_ready", 32'(s_ready), 32'(1));
        @(negedge clk);
        chk("midclr_ready_next_cycle", 32'(s_ready), 32'(1));
        s_wr(4'd1, 4'h4); s_valid = 1'b0;
        idle(3);
        s_cmp_all("post_reset_write");
`endif

        b_wr(11'd2047, 4'h9); b_valid = 1'b0;
        idle(1);
        chk("big_top_entry", 32'(b_out[2047]), 32'h9);
        for (int i = 0; i < 100; i++) b_wr(11'($urandom_range(0, 2047)), 4'($urandom_range(0, 15)));
        b_valid = 1'b0;
        idle(4);
        b_cmp_all("big_random_stream");

        chk("small_queue_drained", 32'(s_q.size()), 32'(0));
        chk("big_queue_drained", 32'(b_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/demux_write_bank_n.md
DEMUX_WRITE_BANK_N -- requirements
Module: demux_write_bank_n

Interface
REQ-001 The block SHALL have parameter n, default 4, giving the data width per entry.
REQ-002 The block SHALL have parameter address, default 11, giving the select width.
REQ-003 The block SHALL have parameter m, default 2048 (m = 2**address, m a multiple of 4), giving the entry count.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port valid_i, input, 1 bit: a write request is present.
REQ-007 The block SHALL have port ready_o, output, 1 bit: the block can accept a request this cycle.
REQ-008 The block SHALL have port sel_i, input, address bits: the target entry index.
REQ-009 The block SHALL have port data_i, input, n bits: the write data.
REQ-010 The block SHALL have port data_o, output, unpacked array [0:m-1] of n bits: registered entry contents.
REQ-011 The block SHALL have port wr_done_o, output, 1 bit: a one-cycle pulse marking that a write has landed.
REQ-012 The block SHALL have port clr_i, input, 1 bit: bulk-clear request (only with DEMUX_BULK_CLEAR_EN).

Function
REQ-013 Handshake SHALL be: a request is accepted on a rising edge where valid_i=1 and ready_o=1; sel_i and data_i SHALL be held only for that cycle.
REQ-014 Write pipeline SHALL be 2 stages. At acceptance edge T0, stage 1 registers sel_i[address-1:2] and decodes it to a one-hot group (m/4 groups of 4). Stage 1 also registers sel_i[1:0], data_i and a valid bit.
REQ-015 At edge T1 = T0+1, stage 2 SHALL write the data into data_o[sel]; all other entries SHALL hold their values.
REQ-016 wr_done_o SHALL be 1 in the cycle following T1 and 0 otherwise.
REQ-017 Throughput SHALL be 1 write per cycle. For back-to-back writes to the same index, the later write SHALL win. There is no hazard stall.
REQ-018 ready_o SHALL be 1 in state IDLE when clr_i=0, and 0 otherwise. ready_o is combinational on state and clr_i.
REQ-019 FSM states SHALL be IDLE, DRAIN and CLEAR. Transitions:
  - IDLE->DRAIN on clr_i=1 when stage 1 is valid.
  - IDLE->CLEAR on clr_i=1 when stage 1 is empty.
  - DRAIN->CLEAR after 1 cycle; the in-flight write lands first.
  - CLEAR->IDLE after the counter reaches m/4-1.
REQ-020 In CLEAR, a counter k of width address-2 SHALL run from 0 to m/4-1. Each cycle, entries 4k..4k+3 SHALL be set to 0, so a clear takes m/4 cycles.
REQ-021 When clr_i=1 and valid_i=1 in the same cycle, clear SHALL take priority and the request SHALL NOT be accepted.
REQ-022 clr_i asserted during DRAIN or CLEAR SHALL be ignored; the clear SHALL NOT restart.
REQ-023 wr_done_o SHALL NOT pulse for clear operations.

Reset
REQ-024 While rst_ni=0, all entries of data_o, the stage-1 registers and wr_done_o SHALL be 0, the counter SHALL be 0, the state SHALL be IDLE and ready_o SHALL be 0.
REQ-025 Reset asserted mid-write or mid-clear SHALL discard the in-flight write and abort the clear immediately.
REQ-026 ready_o SHALL be 1 in the first cycle after rst_ni is released, provided clr_i=0.

Configuration
REQ-027 Macro DEMUX_BULK_CLEAR_EN defined: clr_i exists, and DRAIN, CLEAR and the sweep counter are implemented as above.
REQ-028 Macro DEMUX_BULK_CLEAR_EN undefined: clr_i is absent, the FSM is IDLE only, and ready_o is 1 whenever not in reset. Write behaviour is identical.

Verification
REQ-029 The bench SHALL cover these directed scenarios, with m=16 and address=4 unless stated:
  - Single write: sel=5, data=0xA accepted at edge T0 -> data_o[5]=0xA after T0+1, wr_done_o=1 for exactly one cycle, all other entries 0.
  - Back-to-back writes: sel=3/0x1, sel=3/0x7, sel=12/0xF on consecutive cycles -> data_o[3]=0x7, data_o[12]=0xF, wr_done_o high for 3 consecutive cycles.
  - Clear with write in flight: write sel=9/0x6, then clr_i=1 in the next cycle -> data_o[9]=0x6 lands first, then ready_o=0 for 1+4 cycles and all entries read 0 afterwards.
  - Simultaneous request: clr_i=1 and valid_i=1 together -> write not accepted, no wr_done_o pulse, clear completes.
  - Reset mid-clear: rst_ni=0 during sweep k=2 -> all outputs 0 asynchronously, state IDLE, ready_o=1 one cycle after release.
  - Default parameters (m=2048): write sel=2047/0x9 -> data_o[2047]=0x9; with the macro undefined, a stream of 100 random writes matches a reference model.
